break_ctrl: RTL and testbench
=============================

Name: break_ctrl

Overview:
- Sequences entry to and exit from the kernel break handler in the 5-stage MIPS pipeline.
- Detects breaks in ID: undefined instruction, syscall and external interrupt. Arbitrates them by priority.
- Drives the write enable and data of the PC-on-break register, the IF/ID and ID/EX flushes, and the PC source select.
- Tracks kernel mode and gives the returned instruction a guaranteed forward-progress window after eret.

Parameters:
- IRQ_VECTOR, 32'h80000004, handler entry address for interrupts.
- EXC_VECTOR, 32'h80000008, handler entry address for undefined instruction and syscall.
- CNT_W, 16, width of the saturating break counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- irq  in  1  level interrupt request from the timer; held until irq_ack.
- exc_undef  in  1  ID stage decodes an undefined instruction.
- exc_syscall  in  1  ID stage decodes syscall.
- eret  in  1  ID stage decodes handler return (jr $k0).
- id_valid  in  1  ID holds a real instruction, not a bubble.
- stall  in  1  load-use stall; no break is taken while it is high.
- id_pc  in  32  PC of the instruction in ID.
- epc  in  32  current content of the PC-on-break register.
- pc_wr_en  out  1  write strobe to the PC-on-break register.
- pc_save  out  32  value to write into the PC-on-break register.
- flush_if_id  out  1  squash the IF/ID register.
- flush_id_ex  out  1  squash the ID/EX register (ID instruction becomes a bubble).
- pc_redirect  out  1  override the next PC with pc_target.
- pc_target  out  32  redirect address.
- irq_ack  out  1  one-cycle acknowledge to the timer.
- kernel_mode  out  1  handler is executing.
- cause  out  2  last cause taken: 0 none, 1 irq, 2 undef, 3 syscall.
- break_cnt  out  CNT_W  number of breaks taken, saturating.

Behaviour:
- Reset (reset=0, async):
  - state=USER, kernel_mode=0, cause=0, break_cnt=0.
  - All pulse outputs 0; pc_save and pc_target 0.
- States: USER, KERNEL, RESUME. kernel_mode=1 exactly in KERNEL.
- ok = id_valid & ~stall.
- Break take, combinational, same cycle N:
  - Allowed when state ∈ {USER, RESUME} and ok.
  - Priority: exc_undef > exc_syscall > irq.
  - irq is eligible only in USER, never in RESUME.
  - undef or syscall: pc_save = id_pc + 4 (faulting instruction is skipped); pc_target = EXC_VECTOR; cause = 2 or 3.
  - irq: pc_save = id_pc (instruction is re-executed); pc_target = IRQ_VECTOR; irq_ack=1; cause=1.
  - Every take asserts pc_wr_en, flush_if_id, flush_id_ex and pc_redirect for one cycle only.
  - Next state is KERNEL at N+1; break_cnt increments, saturating at all ones.
- Simultaneous events: only the highest-priority event is taken. A lower-priority irq stays pending because irq is a level signal that is not acked.
- KERNEL:
  - irq is masked; no irq_ack.
  - exc_undef and exc_syscall are ignored: no save, no redirect.
  - eret with ok: pc_redirect=1, pc_target=epc, flush_if_id=1, pc_wr_en=0. Next state is RESUME.
  - eret while stall=1 waits for stall to drop.
- RESUME:
  - Stays until the first cycle with ok, then goes to USER.
  - That instruction always passes unless it is itself undef or syscall, which is taken normally.
  - An irq pending at eret is taken no earlier than the cycle after that instruction leaves ID. This prevents livelock.
- Bubbles: id_valid=0 never triggers a take, even if exc_* glitch high.
- Adder: pc_save for exceptions wraps modulo 2^32, so 32'hFFFFFFFC + 4 = 0.
- Reset mid-handler: returns to USER immediately and asynchronously. No pulse outputs are emitted during or after the reset assertion.

Test Plan:
- Interrupt: USER, id_pc=0x00400010, ok, irq=1 → same cycle pc_wr_en=1, pc_save=0x00400010, pc_target=0x80000004, irq_ack=1, both flushes=1. Next cycle kernel_mode=1, cause=1, break_cnt=1.
- Priority: exc_undef=1, exc_syscall=1, irq=1, id_pc=0x00400020 → pc_save=0x00400024, pc_target=0x80000008, cause=2, irq_ack=0. After eret, RESUME, one ok cycle and USER, the irq is taken with cause=1.
- Stall and bubble gating: syscall with stall=1 for 3 cycles → no take. Take occurs on the first stall=0 cycle with pc_save=id_pc+4. Syscall with id_valid=0 → no take.
- Kernel masking and return: in KERNEL, irq=1 and exc_undef=1 → no outputs. eret with epc=0x00400010 → pc_redirect=1, pc_target=0x00400010, flush_if_id=1, pc_wr_en=0. An irq held high is taken only after one valid ID instruction in RESUME.
- Saturation and wrap: force 65535 breaks → break_cnt stays 0xFFFF. Undef at id_pc=0xFFFFFFFC → pc_save=0.
- Async reset: assert reset=0 mid-KERNEL between clock edges → kernel_mode, cause and break_cnt drop to 0 immediately. After release, the first irq is taken normally from USER.

Source files
------------

// File: rtl/break_ctrl.sv
// rtl/break_ctrl.sv - kernel break entry/exit sequencer for the 5-stage MIPS pipeline
module break_ctrl #(
   parameter logic [31:0] IRQ_VECTOR = 32'h80000004,
   parameter logic [31:0] EXC_VECTOR = 32'h80000008,
   parameter int          CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             irq,
   input  logic             exc_undef,
   input  logic             exc_syscall,
   input  logic             eret,
   input  logic             id_valid,
   input  logic             stall,
   input  logic [31:0]      id_pc,
   input  logic [31:0]      epc,
   output logic             pc_wr_en,
   output logic [31:0]      pc_save,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             pc_redirect,
   output logic [31:0]      pc_target,
   output logic             irq_ack,
   output logic             kernel_mode,
   output logic [1:0]       cause,
   output logic [CNT_W-1:0] break_cnt
);

   typedef enum logic [1:0] {
      USER   = 2'd0,
      KERNEL = 2'd1,
      RESUME = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_IRQ     = 2'd1;
   localparam logic [1:0] CAUSE_UNDEF   = 2'd2;
   localparam logic [1:0] CAUSE_SYSCALL = 2'd3;

   state_t     state;
   state_t     state_nxt;
   logic       ok;
   logic       take;
   logic [1:0] take_cause;

   assign ok          = id_valid & ~stall;
   assign kernel_mode = (state == KERNEL);

   // Pulse outputs are gated by reset so nothing leaks out while it is asserted.
   always_comb begin
      state_nxt   = state;
      take        = 1'b0;
      take_cause  = 2'd0;
      pc_wr_en    = 1'b0;
      pc_save     = 32'd0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      pc_redirect = 1'b0;
      pc_target   = 32'd0;
      irq_ack     = 1'b0;

      if (reset) begin
         case (state)
            USER, RESUME: begin
               if (ok) begin
                  if (exc_undef) begin
                     take       = 1'b1;
                     take_cause = CAUSE_UNDEF;
                  end else if (exc_syscall) begin
                     take       = 1'b1;
                     take_cause = CAUSE_SYSCALL;
                  end else if (irq && state == USER) begin
                     take       = 1'b1;
                     take_cause = CAUSE_IRQ;
                  end
                  state_nxt = USER;
               end
            end
            KERNEL: begin
               if (eret && ok) begin
                  pc_redirect = 1'b1;
                  pc_target   = epc;
                  flush_if_id = 1'b1;
                  state_nxt   = RESUME;
               end
            end
            default: state_nxt = USER;
         endcase

         if (take) begin
            state_nxt   = KERNEL;
            pc_wr_en    = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            pc_redirect = 1'b1;
            if (take_cause == CAUSE_IRQ) begin
               // Interrupted instruction has not executed yet, so it is replayed.
               pc_save   = id_pc;
               pc_target = IRQ_VECTOR;
               irq_ack   = 1'b1;
            end else begin
               pc_save   = id_pc + 32'd4;
               pc_target = EXC_VECTOR;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= USER;
         cause     <= 2'd0;
         break_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (take) begin
            cause <= take_cause;
            if (break_cnt != {CNT_W{1'b1}})
               break_cnt <= break_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_break_ctrl.sv
// tb/tb_break_ctrl.sv - directed self-checking bench for break_ctrl
module tb_break_ctrl;

   logic        clk;
   logic        reset;
   logic        irq;
   logic        exc_undef;
   logic        exc_syscall;
   logic        eret;
   logic        id_valid;
   logic        stall;
   logic [31:0] id_pc;
   logic [31:0] epc;
   logic        pc_wr_en;
   logic [31:0] pc_save;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        pc_redirect;
   logic [31:0] pc_target;
   logic        irq_ack;
   logic        kernel_mode;
   logic [1:0]  cause;
   logic [15:0] break_cnt;

   logic        s_pc_wr_en;
   logic [31:0] s_pc_save;
   logic        s_flush_if_id;
   logic        s_flush_id_ex;
   logic        s_pc_redirect;
   logic [31:0] s_pc_target;
   logic        s_irq_ack;
   logic        s_kernel_mode;
   logic [1:0]  s_cause;
   logic [2:0]  s_break_cnt;

   int n_chk;
   int n_err;
   int exp_cnt;
   int exp_sat;

   break_ctrl u_dut (
      .clk(clk), .reset(reset), .irq(irq), .exc_undef(exc_undef),
      .exc_syscall(exc_syscall), .eret(eret), .id_valid(id_valid), .stall(stall),
      .id_pc(id_pc), .epc(epc), .pc_wr_en(pc_wr_en), .pc_save(pc_save),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .pc_redirect(pc_redirect),
      .pc_target(pc_target), .irq_ack(irq_ack), .kernel_mode(kernel_mode),
      .cause(cause), .break_cnt(break_cnt)
   );

   // Narrow counter copy so saturation is reachable in a few cycles.
   break_ctrl #(.CNT_W(3)) u_sat (
      .clk(clk), .reset(reset), .irq(irq), .exc_undef(exc_undef),
      .exc_syscall(exc_syscall), .eret(eret), .id_valid(id_valid), .stall(stall),
      .id_pc(id_pc), .epc(epc), .pc_wr_en(s_pc_wr_en), .pc_save(s_pc_save),
      .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex), .pc_redirect(s_pc_redirect),
      .pc_target(s_pc_target), .irq_ack(s_irq_ack), .kernel_mode(s_kernel_mode),
      .cause(s_cause), .break_cnt(s_break_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      irq = 1'b0; exc_undef = 1'b0; exc_syscall = 1'b0; eret = 1'b0;
      id_valid = 1'b0; stall = 1'b0;
   endtask

   task automatic bump();
      exp_cnt = exp_cnt + 1;
      if (exp_sat != 7) exp_sat = exp_sat + 1;
   endtask

   // From KERNEL: eret, then one plain instruction in RESUME, ending in USER.
   task automatic leave_kernel();
      idle();
      eret = 1'b1; id_valid = 1'b1;
      tick();
      eret = 1'b0; id_valid = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_reset();
      irq = 1'b1; id_valid = 1'b1; id_pc = 32'h00000010;
      #2;
      n_chk++; if (kernel_mode !== 1'b0) begin n_err++; $display("FAIL rst_kernel_mode: got %0b want 0", kernel_mode); end
      n_chk++; if (cause !== 2'd0) begin n_err++; $display("FAIL rst_cause: got %0d want 0", cause); end
      n_chk++; if (break_cnt !== 16'd0) begin n_err++; $display("FAIL rst_break_cnt: got %0d want 0", break_cnt); end
      n_chk++; if ({pc_wr_en, flush_if_id, flush_id_ex, pc_redirect, irq_ack} !== 5'b0) begin n_err++; $display("FAIL rst_pulses: got %b want 00000", {pc_wr_en, flush_if_id, flush_id_ex, pc_redirect, irq_ack}); end
      n_chk++; if (pc_save !== 32'd0 || pc_target !== 32'd0) begin n_err++; $display("FAIL rst_pc: got save=%h target=%h want 0/0", pc_save, pc_target); end
      tick();
      tick();
      n_chk++; if (kernel_mode !== 1'b0 || irq_ack !== 1'b0) begin n_err++; $display("FAIL rst_held: got km=%0b ack=%0b want 0/0", kernel_mode, irq_ack); end
      idle();
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_irq();
      id_pc = 32'h00400010; id_valid = 1'b1; irq = 1'b1;
      #1;
      n_chk++; if (pc_wr_en !== 1'b1) begin n_err++; $display("FAIL irq_wr_en: got %0b want 1", pc_wr_en); end
      n_chk++; if (pc_save !== 32'h00400010) begin n_err++; $display("FAIL irq_pc_save: got %h want 00400010", pc_save); end
      n_chk++; if (pc_target !== 32'h80000004) begin n_err++; $display("FAIL irq_pc_target: got %h want 80000004", pc_target); end
      n_chk++; if (irq_ack !== 1'b1) begin n_err++; $display("FAIL irq_ack: got %0b want 1", irq_ack); end
      n_chk++; if ({flush_if_id, flush_id_ex, pc_redirect} !== 3'b111) begin n_err++; $display("FAIL irq_flush: got %b want 111", {flush_if_id, flush_id_ex, pc_redirect}); end
      tick();
      bump();
      irq = 1'b0; id_valid = 1'b0;
      #1;
      n_chk++; if (kernel_mode !== 1'b1) begin n_err++; $display("FAIL irq_kernel_mode: got %0b want 1", kernel_mode); end
      n_chk++; if (cause !== 2'd1) begin n_err++; $display("FAIL irq_cause: got %0d want 1", cause); end
      n_chk++; if (break_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL irq_break_cnt: got %0d want %0d", break_cnt, exp_cnt); end
      n_chk++; if (pc_wr_en !== 1'b0) begin n_err++; $display("FAIL irq_one_cycle: got wr_en=%0b want 0", pc_wr_en); end
      eret = 1'b1; id_valid = 1'b1; epc = 32'h00400010;
      #1;
      n_chk++; if (pc_redirect !== 1'b1 || pc_target !== 32'h00400010) begin n_err++; $display("FAIL eret_redirect: got %0b/%h want 1/00400010", pc_redirect, pc_target); end
      n_chk++; if ({flush_if_id, pc_wr_en, flush_id_ex} !== 3'b100) begin n_err++; $display("FAIL eret_flags: got %b want 100", {flush_if_id, pc_wr_en, flush_id_ex}); end
      tick();
      eret = 1'b0;
      #1;
      n_chk++; if (kernel_mode !== 1'b0) begin n_err++; $display("FAIL eret_leave: got km=%0b want 0", kernel_mode); end
      tick();
      idle();
   endtask

   task automatic test_priority();
      exc_undef = 1'b1; exc_syscall = 1'b1; irq = 1'b1; id_valid = 1'b1; id_pc = 32'h00400020;
      #1;
      n_chk++; if (pc_save !== 32'h00400024) begin n_err++; $display("FAIL prio_pc_save: got %h want 00400024", pc_save); end
      n_chk++; if (pc_target !== 32'h80000008) begin n_err++; $display("FAIL prio_pc_target: got %h want 80000008", pc_target); end
      n_chk++; if (irq_ack !== 1'b0) begin n_err++; $display("FAIL prio_irq_ack: got %0b want 0", irq_ack); end
      tick();
      bump();
      exc_undef = 1'b0; exc_syscall = 1'b0;
      #1;
      n_chk++; if (cause !== 2'd2) begin n_err++; $display("FAIL prio_cause: got %0d want 2", cause); end
      n_chk++; if (irq_ack !== 1'b0 || pc_wr_en !== 1'b0) begin n_err++; $display("FAIL prio_kernel_mask: got ack=%0b wr=%0b want 0/0", irq_ack, pc_wr_en); end
      eret = 1'b1; epc = 32'h00400024;
      tick();
      eret = 1'b0; id_pc = 32'h00400024;
      #1;
      n_chk++; if (irq_ack !== 1'b0 || pc_wr_en !== 1'b0) begin n_err++; $display("FAIL prio_resume_pass: got ack=%0b wr=%0b want 0/0", irq_ack, pc_wr_en); end
      tick();
      id_pc = 32'h00400028;
      #1;
      n_chk++; if (irq_ack !== 1'b1 || pc_save !== 32'h00400028) begin n_err++; $display("FAIL prio_irq_later: got ack=%0b save=%h want 1/00400028", irq_ack, pc_save); end
      tick();
      bump();
      n_chk++; if (cause !== 2'd1) begin n_err++; $display("FAIL prio_irq_cause: got %0d want 1", cause); end
      leave_kernel();
   endtask

   task automatic test_stall_bubble();
      exc_syscall = 1'b1; id_valid = 1'b1; stall = 1'b1; id_pc = 32'h00400100;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if (pc_wr_en !== 1'b0 || pc_redirect !== 1'b0) begin n_err++; $display("FAIL stall_no_take_%0d: got wr=%0b redir=%0b want 0/0", i, pc_wr_en, pc_redirect); end
         tick();
      end
      stall = 1'b0;
      #1;
      n_chk++; if (pc_wr_en !== 1'b1 || pc_save !== 32'h00400104) begin n_err++; $display("FAIL stall_take: got wr=%0b save=%h want 1/00400104", pc_wr_en, pc_save); end
      tick();
      bump();
      n_chk++; if (cause !== 2'd3 || kernel_mode !== 1'b1) begin n_err++; $display("FAIL stall_cause: got cause=%0d km=%0b want 3/1", cause, kernel_mode); end
      leave_kernel();
      exc_syscall = 1'b1; exc_undef = 1'b1; id_valid = 1'b0;
      #1;
      n_chk++; if ({pc_wr_en, flush_id_ex, pc_redirect} !== 3'b000) begin n_err++; $display("FAIL bubble_no_take: got %b want 000", {pc_wr_en, flush_id_ex, pc_redirect}); end
      tick();
      n_chk++; if (kernel_mode !== 1'b0) begin n_err++; $display("FAIL bubble_state: got km=%0b want 0", kernel_mode); end
      idle();
   endtask

   task automatic test_kernel_mask();
      exc_syscall = 1'b1; id_valid = 1'b1; id_pc = 32'h00400200;
      tick();
      bump();
      exc_syscall = 1'b0; irq = 1'b1; exc_undef = 1'b1;
      #1;
      n_chk++; if ({pc_wr_en, flush_if_id, flush_id_ex, pc_redirect, irq_ack} !== 5'b0) begin n_err++; $display("FAIL kmask_pulses: got %b want 00000", {pc_wr_en, flush_if_id, flush_id_ex, pc_redirect, irq_ack}); end
      tick();
      n_chk++; if (kernel_mode !== 1'b1 || cause !== 2'd3) begin n_err++; $display("FAIL kmask_state: got km=%0b cause=%0d want 1/3", kernel_mode, cause); end
      exc_undef = 1'b0; eret = 1'b1; stall = 1'b1; epc = 32'h00400204;
      #1;
      n_chk++; if (pc_redirect !== 1'b0) begin n_err++; $display("FAIL eret_stall: got redir=%0b want 0", pc_redirect); end
      tick();
      stall = 1'b0;
      #1;
      n_chk++; if (pc_redirect !== 1'b1 || pc_target !== 32'h00400204) begin n_err++; $display("FAIL eret_unstall: got %0b/%h want 1/00400204", pc_redirect, pc_target); end
      tick();
      eret = 1'b0; id_valid = 1'b0;
      #1;
      n_chk++; if (pc_wr_en !== 1'b0) begin n_err++; $display("FAIL resume_bubble: got wr=%0b want 0", pc_wr_en); end
      tick();
      id_valid = 1'b1;
      #1;
      n_chk++; if (irq_ack !== 1'b0) begin n_err++; $display("FAIL resume_first_ok: got ack=%0b want 0", irq_ack); end
      tick();
      #1;
      n_chk++; if (irq_ack !== 1'b1 || pc_target !== 32'h80000004) begin n_err++; $display("FAIL resume_then_irq: got ack=%0b target=%h want 1/80000004", irq_ack, pc_target); end
      tick();
      bump();
      leave_kernel();
   endtask

   task automatic test_wrap();
      exc_undef = 1'b1; id_valid = 1'b1; id_pc = 32'hFFFFFFFC;
      #1;
      n_chk++; if (pc_save !== 32'h00000000 || pc_target !== 32'h80000008) begin n_err++; $display("FAIL wrap_pc_save: got save=%h target=%h want 00000000/80000008", pc_save, pc_target); end
      tick();
      bump();
      n_chk++; if (cause !== 2'd2) begin n_err++; $display("FAIL wrap_cause: got %0d want 2", cause); end
      leave_kernel();
   endtask

   task automatic test_saturation();
      exc_undef = 1'b1; id_valid = 1'b1; id_pc = 32'h00400300;
      tick();
      bump();
      for (int i = 0; i < 9; i++) begin
         exc_undef = 1'b0; eret = 1'b1;
         tick();
         eret = 1'b0; exc_undef = 1'b1;
         tick();
         bump();
      end
      n_chk++; if (s_break_cnt !== 3'(exp_sat)) begin n_err++; $display("FAIL sat_cnt: got %0d want %0d", s_break_cnt, exp_sat); end
      n_chk++; if (s_break_cnt !== 3'd7) begin n_err++; $display("FAIL sat_cnt_max: got %0d want 7", s_break_cnt); end
      n_chk++; if (break_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL sat_main_cnt: got %0d want %0d", break_cnt, exp_cnt); end
      leave_kernel();
   endtask

   task automatic test_async_reset();
      exc_syscall = 1'b1; id_valid = 1'b1; id_pc = 32'h00400400;
      tick();
      bump();
      idle();
      #2;
      reset = 1'b0;
      #1;
      exp_cnt = 0; exp_sat = 0;
      n_chk++; if (kernel_mode !== 1'b0 || cause !== 2'd0 || break_cnt !== 16'd0) begin n_err++; $display("FAIL arst_clear: got km=%0b cause=%0d cnt=%0d want 0/0/0", kernel_mode, cause, break_cnt); end
      irq = 1'b1; id_valid = 1'b1; id_pc = 32'h00400500;
      #1;
      n_chk++; if (irq_ack !== 1'b0 || pc_wr_en !== 1'b0) begin n_err++; $display("FAIL arst_no_pulse: got ack=%0b wr=%0b want 0/0", irq_ack, pc_wr_en); end
      tick();
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_chk++; if (irq_ack !== 1'b1 || pc_save !== 32'h00400500) begin n_err++; $display("FAIL arst_irq_take: got ack=%0b save=%h want 1/00400500", irq_ack, pc_save); end
      tick();
      bump();
      n_chk++; if (cause !== 2'd1 || break_cnt !== 16'(exp_cnt)) begin n_err++; $display("FAIL arst_irq_cause: got cause=%0d cnt=%0d want 1/%0d", cause, break_cnt, exp_cnt); end
      leave_kernel();
   endtask

   initial begin
      n_chk = 0; n_err = 0; exp_cnt = 0; exp_sat = 0;
      reset = 1'b0;
      idle();
      id_pc = 32'd0; epc = 32'd0;
      test_reset();
      test_irq();
      test_priority();
      test_stall_bubble();
      test_kernel_mask();
      test_wrap();
      test_saturation();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
